// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the lock FSM state encoding and the modulo-N pointer increment.
package stream_rr_arbiter_pkg;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Increment that wraps at n, so non-power-of-two input counts never overflow the pointer.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Valid/ready bundle for the arbiter: N_INP input streams and one output stream.
// The slave modport is the arbiter side, the master modport is the environment side.
interface stream_rr_arbiter_if #(
    parameter type DATA_T = logic [7:0],
    parameter int  N_INP  = 2
);

    DATA_T            inp_data_i [N_INP];
    logic [N_INP-1:0] inp_valid_i;
    logic [N_INP-1:0] inp_ready_o;
    DATA_T            oup_data_o;
    logic             oup_valid_o;
    logic             oup_ready_i;

    modport slave (
        input  inp_data_i,
        input  inp_valid_i,
        input  oup_ready_i,
        output inp_ready_o,
        output oup_data_o,
        output oup_valid_o
    );

    modport master (
        output inp_data_i,
        output inp_valid_i,
        output oup_ready_i,
        input  inp_ready_o,
        input  oup_data_o,
        input  oup_valid_o
    );

endinterface

// File: rtl/stream_rr_arbiter_grant_search.sv
// Rotating first-one finder: scans requests starting at the pointer and wrapping,
// returning the first requesting index and whether any request was found.
module rr_grant_search #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        int  c;
        logic hit;
        o_idx   = '0;
        o_found = 1'b0;
        c       = 0;
        hit     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            c = int'(i_ptr) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            hit = 1'b0;
            for (int j = 0; j < N_REQ; j++) begin
                if (j == c) begin
                    hit = i_req[j];
                end
            end
            if (!o_found && hit) begin
                o_found = 1'b1;
                o_idx   = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging N_INP valid/ready streams onto one output with zero latency.
// A stalled grant is locked until it transfers so the downstream sees stable data.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter type DATA_T = logic [7:0],
    parameter int  N_INP  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    stream_rr_arbiter_if.slave  bus
);

    localparam int PTR_W = (N_INP > 1) ? $clog2(N_INP) : 1;

    generate
        if (N_INP < 1 || $bits(DATA_T) < 1) begin : g_bad_cfg
            $fatal(1, "stream_rr_arbiter: N_INP and payload width must both be at least 1");
        end
    endgenerate

    arb_state_e       r_state;
    arb_state_e       w_stateNext;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptrNext;
    logic [PTR_W-1:0] r_lockIdx;
    logic [PTR_W-1:0] w_lockIdxNext;
    logic [PTR_W-1:0] w_searchIdx;
    logic [PTR_W-1:0] w_grant;
    logic             w_found;
    logic             w_anyValid;
    logic             w_xfer;

    rr_grant_search #(
        .N_REQ (N_INP),
        .PTR_W (PTR_W)
    ) u_search (
        .i_req   (bus.inp_valid_i),
        .i_ptr   (r_ptr),
        .o_idx   (w_searchIdx),
        .o_found (w_found)
    );

    // Reset gates the output valid so nothing can transfer while rst_i is held.
    assign w_anyValid      = w_found & ~rst_i;
    assign w_grant         = (r_state == ST_LOCKED) ? r_lockIdx : w_searchIdx;
    assign w_xfer          = w_anyValid & bus.oup_ready_i;
    assign bus.oup_valid_o = w_anyValid;

    always_comb begin
        bus.oup_data_o  = bus.inp_data_i[0];
        bus.inp_ready_o = '0;
        for (int k = 0; k < N_INP; k++) begin
            if (w_grant == PTR_W'(k)) begin
                bus.oup_data_o     = bus.inp_data_i[k];
                bus.inp_ready_o[k] = w_xfer;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_lockIdxNext = r_lockIdx;
        w_ptrNext     = r_ptr;
        if (w_xfer) begin
            w_ptrNext = PTR_W'(wrap_inc(int'(w_grant), N_INP));
        end
        case (r_state)
            ST_FREE: begin
                if (w_anyValid && !bus.oup_ready_i) begin
                    w_stateNext   = ST_LOCKED;
                    w_lockIdxNext = w_searchIdx;
                end
            end
            ST_LOCKED: begin
                if (w_xfer) begin
                    w_stateNext = ST_FREE;
                end
            end
            default: begin
                w_stateNext = ST_FREE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_FREE;
            r_ptr     <= '0;
            r_lockIdx <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_ptr     <= w_ptrNext;
            r_lockIdx <= w_lockIdxNext;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed scoreboard bench for stream_rr_arbiter with 4-, 3- and 1-input instances.
// Expected grants are queued as stimulus is applied and compared once outputs settle.
module tb_stream_rr_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    typedef struct {
        string      tag;
        int         dut;
        logic       vld;
        logic [7:0] data;
        logic [3:0] rdy;
    } exp_t;

    exp_t sb[$];

    stream_rr_arbiter_if #(.DATA_T(logic [7:0]), .N_INP(4)) if4 ();
    stream_rr_arbiter_if #(.DATA_T(logic [7:0]), .N_INP(3)) if3 ();
    stream_rr_arbiter_if #(.DATA_T(logic [7:0]), .N_INP(1)) if1 ();

    stream_rr_arbiter #(.DATA_T(logic [7:0]), .N_INP(4)) u4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if4)
    );

    stream_rr_arbiter #(.DATA_T(logic [7:0]), .N_INP(3)) u3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if3)
    );

    stream_rr_arbiter #(.DATA_T(logic [7:0]), .N_INP(1)) u1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int dut, input logic [3:0] valid, input logic ready);
        case (dut)
            4: begin
                if4.inp_valid_i = valid;
                if4.oup_ready_i = ready;
            end
            3: begin
                if3.inp_valid_i = valid[2:0];
                if3.oup_ready_i = ready;
            end
            default: begin
                if1.inp_valid_i = valid[0];
                if1.oup_ready_i = ready;
            end
        endcase
    endtask

    task automatic expectOut(input string tag, input int dut, input logic vld,
                             input logic [7:0] data, input logic [3:0] rdy);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.vld  = vld;
        e.data = data;
        e.rdy  = rdy;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic       oV;
        logic [7:0] oD;
        logic [3:0] oR;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: got 0 entries want at least 1");
        end else begin
            e = sb.pop_front();
            case (e.dut)
                4: begin
                    oV = if4.oup_valid_o;
                    oD = if4.oup_data_o;
                    oR = if4.inp_ready_o;
                end
                3: begin
                    oV = if3.oup_valid_o;
                    oD = if3.oup_data_o;
                    oR = {1'b0, if3.inp_ready_o};
                end
                default: begin
                    oV = if1.oup_valid_o;
                    oD = if1.oup_data_o;
                    oR = {3'b000, if1.inp_ready_o};
                end
            endcase
            checks++;
            assert (oV === e.vld) else begin
                errors++;
                $error("FAIL %s valid: got %b want %b", e.tag, oV, e.vld);
            end
            if (e.vld) begin
                checks++;
                assert (oD === e.data) else begin
                    errors++;
                    $error("FAIL %s data: got %h want %h", e.tag, oD, e.data);
                end
            end
            checks++;
            assert (oR === e.rdy) else begin
                errors++;
                $error("FAIL %s ready: got %b want %b", e.tag, oR, e.rdy);
            end
        end
    endtask

    task automatic probe(input string tag, input int dut, input logic vld,
                         input logic [7:0] data, input logic [3:0] rdy);
        expectOut(tag, dut, vld, data, rdy);
        #1;
        checkOutput();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if4.inp_data_i[k] = 8'(8'hA0 + k);
        end
        for (int k = 0; k < 3; k++) begin
            if3.inp_data_i[k] = 8'(8'hB0 + k);
        end
        if1.inp_data_i[0] = 8'hA5;
        applyStimulus(3, 4'b0000, 1'b0);

        // Outputs must be gated off while reset is held, even with requests pending.
        applyStimulus(4, 4'b1111, 1'b1);
        applyStimulus(1, 4'b0001, 1'b1);
        probe("rst_gate4", 4, 1'b0, 8'h00, 4'b0000);
        probe("rst_gate1", 1, 1'b0, 8'h00, 4'b0000);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        applyStimulus(4, 4'b0000, 1'b0);
        applyStimulus(1, 4'b0000, 1'b0);
        stepCycle();

        applyStimulus(4, 4'b1010, 1'b1);
        probe("sparse_g1", 4, 1'b1, 8'hA1, 4'b0010);
        stepCycle();
        probe("sparse_g3", 4, 1'b1, 8'hA3, 4'b1000);
        stepCycle();

        applyStimulus(4, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            probe($sformatf("rr_all_%0d", i), 4, 1'b1, 8'(8'hA0 + (i % 4)), 4'(1 << (i % 4)));
            stepCycle();
        end

        // Input 0 rises while grant 2 is stalled; the lock must hold grant 2.
        applyStimulus(4, 4'b0100, 1'b0);
        probe("lock_g2", 4, 1'b1, 8'hA2, 4'b0000);
        stepCycle();
        applyStimulus(4, 4'b0101, 1'b0);
        probe("lock_hold0", 4, 1'b1, 8'hA2, 4'b0000);
        stepCycle();
        probe("lock_hold1", 4, 1'b1, 8'hA2, 4'b0000);
        stepCycle();
        applyStimulus(4, 4'b0101, 1'b1);
        probe("lock_xfer", 4, 1'b1, 8'hA2, 4'b0100);
        stepCycle();
        applyStimulus(4, 4'b0001, 1'b1);
        probe("after_lock_g0", 4, 1'b1, 8'hA0, 4'b0001);
        stepCycle();

        applyStimulus(4, 4'b1000, 1'b0);
        probe("stall_g3", 4, 1'b1, 8'hA3, 4'b0000);
        stepCycle();
        applyStimulus(4, 4'b1111, 1'b0);
        probe("stall_g3_hold", 4, 1'b1, 8'hA3, 4'b0000);
        #1;
        rst = 1'b1;
        applyStimulus(4, 4'b1111, 1'b1);
        probe("rst_mid_stall", 4, 1'b0, 8'h00, 4'b0000);
        stepCycle();
        probe("rst_held", 4, 1'b0, 8'h00, 4'b0000);
        rst = 1'b0;
        probe("rst_restart_g0", 4, 1'b1, 8'hA0, 4'b0001);
        stepCycle();
        applyStimulus(4, 4'b0000, 1'b0);

        applyStimulus(3, 4'b0100, 1'b1);
        probe("n3_only2", 3, 1'b1, 8'hB2, 4'b0100);
        stepCycle();
        applyStimulus(3, 4'b0011, 1'b1);
        probe("n3_wrap_g0", 3, 1'b1, 8'hB0, 4'b0001);
        stepCycle();
        probe("n3_g1", 3, 1'b1, 8'hB1, 4'b0010);
        stepCycle();
        applyStimulus(3, 4'b0111, 1'b1);
        probe("n3_g2", 3, 1'b1, 8'hB2, 4'b0100);
        stepCycle();
        probe("n3_g0_again", 3, 1'b1, 8'hB0, 4'b0001);
        stepCycle();
        applyStimulus(3, 4'b0000, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 4'b0001, ((i % 2) == 0));
            probe($sformatf("n1_pass_%0d", i), 1, 1'b1, 8'hA5, {3'b000, ((i % 2) == 0)});
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
